// File: rtl/rpn_eval_sched_if.sv
// rpn_eval_sched_if
//   Bundles the three handshakes of the postfix evaluation scheduler:
//   token input, shared ALU request/response, and result output.
//
//   Token input:  in_stb / in_data / in_is_op (to scheduler), in_ack (from scheduler)
//   ALU:          alu_req / alu_op / alu_a / alu_b (from scheduler),
//                 alu_ack / alu_result (to scheduler)
//   Result:       out_stb / out_data / err (from scheduler), out_ack (to scheduler)
//
//   Modports:
//     master - the surrounding system: token source, ALU and output stage
//     slave  - the scheduler itself
interface rpn_eval_sched_if #(
  parameter int WIDTH = 32
) ();

  // token stream from the infix-to-postfix converter
  logic             in_stb;
  logic [WIDTH-1:0] in_data;
  logic             in_is_op;
  logic             in_ack;

  // shared multi-cycle ALU
  logic             alu_req;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_ack;
  logic [WIDTH-1:0] alu_result;

  // result towards the calculator output stage
  logic             out_stb;
  logic [WIDTH-1:0] out_data;
  logic             out_ack;
  logic [2:0]       err;

  modport master (
    output in_stb, in_data, in_is_op,
    input  in_ack,
    input  alu_req, alu_op, alu_a, alu_b,
    output alu_ack, alu_result,
    input  out_stb, out_data, err,
    output out_ack
  );

  modport slave (
    input  in_stb, in_data, in_is_op,
    output in_ack,
    output alu_req, alu_op, alu_a, alu_b,
    input  alu_ack, alu_result,
    output out_stb, out_data, err,
    input  out_ack
  );

endinterface

// File: rtl/rpn_eval_sched.sv
// rpn_eval_sched
//   Postfix (RPN) evaluation scheduler. Numbers from the token stream are
//   pushed onto an internal operand stack; each operator pops two operands,
//   hands them to the shared external ALU and pushes the ALU result back;
//   '=' delivers the single remaining stack entry to the output stage.
//   Any error (underflow, overflow, unknown operator code) switches to a
//   drain mode that swallows tokens up to the next '=', then reports a
//   zero result with the sticky error flags still visible.
//
//   Parameters:
//     WIDTH - operand/result width
//     DEPTH - operand stack entries (must be >= 2)
//
//   Ports:
//     CLK   - clock, all state updates on the rising edge
//     RST_N - asynchronous active-low reset
//     bus   - rpn_eval_sched_if.slave (token in, ALU, result out)
//
//   Operator codes in in_data[2:0]: '*'=001 '+'=010 '-'=011 '='=100.
//   err[0] = stack underflow, err[1] = stack overflow, err[2] = bad op code.
module rpn_eval_sched #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  rpn_eval_sched_if.slave   bus
);

  // sp counts 0..DEPTH inclusive, so it needs one more value than the
  // stack address.
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0] SP_TWO  = SPW'(2);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_EQ  = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_OPER,
    S_ALU_WAIT,
    S_EMIT,
    S_DRAIN
  } state_t;

  state_t           state_reg;
  logic [SPW-1:0]   sp_reg;
  logic             in_ack_reg;
  logic             alu_req_reg;
  logic [2:0]       alu_op_reg;
  logic [WIDTH-1:0] alu_a_reg;
  logic [WIDTH-1:0] alu_b_reg;
  logic             out_stb_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [2:0]       err_reg;

  // operand stack storage and its single write port
  logic [WIDTH-1:0] stack_mem [DEPTH];
  logic             stack_we;
  logic [AW-1:0]    stack_waddr;
  logic [WIDTH-1:0] stack_wdata;

  // addresses of the top-of-stack (right operand) and the entry below it
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    nxt_idx;

  logic             tok_valid;
  logic [2:0]       tok_code;

  // While in_ack is high the source is still showing the token that was
  // just consumed (it only sees the ack at the end of this cycle), so a
  // token is only sampled when no ack is outstanding. This is also what
  // guarantees at least one idle cycle between consecutive in_ack pulses.
  assign tok_valid = bus.in_stb && !in_ack_reg;
  assign tok_code  = bus.in_data[2:0];

  assign top_idx = sp_reg[AW-1:0] - AW'(1);
  assign nxt_idx = sp_reg[AW-1:0] - AW'(2);

  // Stack writes come from two places: a pushed number (data still held on
  // in_data) or the ALU result returned at the freed slot.
  always_comb begin
    stack_we    = 1'b0;
    stack_waddr = sp_reg[AW-1:0];
    stack_wdata = bus.in_data;
    case (state_reg)
      S_PUSH: begin
        stack_we = (sp_reg < SP_FULL);
      end
      S_ALU_WAIT: begin
        stack_we    = bus.alu_ack;
        stack_wdata = bus.alu_result;
      end
      default: begin
        stack_we = 1'b0;
      end
    endcase
  end

  // Storage has no reset: a reset only clears sp, which makes every entry
  // unreachable until it is written again.
  always_ff @(posedge CLK) begin
    if (stack_we) begin
      stack_mem[stack_waddr] <= stack_wdata;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= S_IDLE;
      sp_reg       <= '0;
      in_ack_reg   <= 1'b0;
      alu_req_reg  <= 1'b0;
      alu_op_reg   <= 3'b000;
      alu_a_reg    <= '0;
      alu_b_reg    <= '0;
      out_stb_reg  <= 1'b0;
      out_data_reg <= '0;
      err_reg      <= 3'b000;
    end else begin
      // in_ack is a single-cycle pulse
      in_ack_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (tok_valid) begin
            if (!bus.in_is_op) begin
              state_reg <= S_PUSH;
            end else begin
              case (tok_code)
                OP_MUL, OP_ADD, OP_SUB: state_reg <= S_OPER;
                OP_EQ:                  state_reg <= S_EMIT;
                default: begin
                  // unknown operator: the token stays pending and is
                  // acknowledged by the drain logic
                  err_reg[2] <= 1'b1;
                  state_reg  <= S_DRAIN;
                end
              endcase
            end
          end
        end

        S_PUSH: begin
          if (sp_reg < SP_FULL) begin
            sp_reg     <= sp_reg + SP_ONE;
            in_ack_reg <= 1'b1;
            state_reg  <= S_IDLE;
          end else begin
            // overflowing number is not stored; drain acks it next
            err_reg[1] <= 1'b1;
            state_reg  <= S_DRAIN;
          end
        end

        S_OPER: begin
          if (sp_reg < SP_TWO) begin
            err_reg[0] <= 1'b1;
            state_reg  <= S_DRAIN;
          end else begin
            alu_b_reg   <= stack_mem[top_idx];
            alu_a_reg   <= stack_mem[nxt_idx];
            alu_op_reg  <= tok_code;
            sp_reg      <= sp_reg - SP_TWO;
            alu_req_reg <= 1'b1;
            state_reg   <= S_ALU_WAIT;
          end
        end

        S_ALU_WAIT: begin
          // request and operands are simply left untouched while waiting
          if (bus.alu_ack) begin
            sp_reg      <= sp_reg + SP_ONE;
            alu_req_reg <= 1'b0;
            in_ack_reg  <= 1'b1;
            state_reg   <= S_IDLE;
          end
        end

        S_EMIT: begin
          // out_stb doubles as the sub-state: low = check stack, high =
          // waiting for the output stage
          if (!out_stb_reg) begin
            if (sp_reg != SP_ONE) begin
              // '=' stays pending; drain sees it and emits the zero result
              err_reg[0] <= 1'b1;
              state_reg  <= S_DRAIN;
            end else begin
              out_data_reg <= stack_mem[0];
              out_stb_reg  <= 1'b1;
            end
          end else if (bus.out_ack) begin
            out_stb_reg <= 1'b0;
            sp_reg      <= '0;
            in_ack_reg  <= 1'b1;
            state_reg   <= S_IDLE;
          end
        end

        S_DRAIN: begin
          if (out_stb_reg) begin
            // flags remain visible until the zero result is taken
            if (bus.out_ack) begin
              out_stb_reg <= 1'b0;
              err_reg     <= 3'b000;
              sp_reg      <= '0;
              in_ack_reg  <= 1'b1;
              state_reg   <= S_IDLE;
            end
          end else if (tok_valid) begin
            if (bus.in_is_op && (tok_code == OP_EQ)) begin
              out_data_reg <= '0;
              out_stb_reg  <= 1'b1;
            end else begin
              in_ack_reg <= 1'b1;
            end
          end
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ack   = in_ack_reg;
  assign bus.alu_req  = alu_req_reg;
  assign bus.alu_op   = alu_op_reg;
  assign bus.alu_a    = alu_a_reg;
  assign bus.alu_b    = alu_b_reg;
  assign bus.out_stb  = out_stb_reg;
  assign bus.out_data = out_data_reg;
  assign bus.err      = err_reg;

endmodule

// File: tb/tb_rpn_eval_sched.sv
module tb_rpn_eval_sched;

  localparam int W = 32;
  localparam int D = 4;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  always #5 CLK = ~CLK;

  rpn_eval_sched_if #(.WIDTH(W)) bus ();

  rpn_eval_sched #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  typedef struct packed {
    logic         is_op;
    logic [W-1:0] d;
  } tok_t;

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } aop_t;

  tok_t         tq[$];
  aop_t         exp_ops[$];
  aop_t         got_ops[$];
  logic [W-1:0] exp_res;
  logic [2:0]   exp_err;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  int   alu_lat = 1;
  int   out_dly = 0;
  int   alu_cnt = 0;
  int   out_cnt = 0;
  aop_t alu_cur;
  int           got_out_n;
  logic [W-1:0] got_val;
  logic [2:0]   got_err;
  logic prev_ack   = 1'b0;
  logic tok_active = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ALU arithmetic (the external ALU behaviour, modulo 2^W)
  function automatic logic [W-1:0] calc(input logic [2:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    case (op)
      3'b001:  return a * b;
      3'b010:  return a + b;
      default: return a - b;
    endcase
  endfunction

  // Evaluate the token list tq as an RPN expression with a bounded stack.
  function automatic void model();
    logic [W-1:0] st[$];
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic bad;
    logic done;
    bad  = 1'b0;
    done = 1'b0;
    exp_ops.delete();
    exp_res = '0;
    exp_err = 3'b000;
    for (int i = 0; i < tq.size() && !done; i++) begin
      if (bad) begin
        if (tq[i].is_op && tq[i].d[2:0] == 3'b100) done = 1'b1;
      end else if (!tq[i].is_op) begin
        if (st.size() == D) begin
          exp_err[1] = 1'b1;
          bad = 1'b1;
        end else begin
          st.push_back(tq[i].d);
        end
      end else begin
        case (tq[i].d[2:0])
          3'b001, 3'b010, 3'b011: begin
            if (st.size() < 2) begin
              exp_err[0] = 1'b1;
              bad = 1'b1;
            end else begin
              b = st.pop_back();
              a = st.pop_back();
              exp_ops.push_back({tq[i].d[2:0], a, b});
              st.push_back(calc(tq[i].d[2:0], a, b));
            end
          end
          3'b100: begin
            if (st.size() == 1) exp_res = st[0];
            else exp_err[0] = 1'b1;
            done = 1'b1;
          end
          default: begin
            exp_err[2] = 1'b1;
            bad = 1'b1;
          end
        endcase
      end
    end
  endfunction

  // One clock cycle of the environment: watch in_ack, act as ALU and
  // as output stage. Everything happens on the falling edge.
  task automatic tick();
    @(negedge CLK);
    if (bus.in_ack) begin
      check("in_ack_gap", 32'(prev_ack), 32'(0));
      check("in_ack_solicited", 32'(tok_active), 32'(1));
    end
    prev_ack = bus.in_ack;

    if (bus.alu_req) begin
      if (alu_cnt == 0) begin
        alu_cur = {bus.alu_op, bus.alu_a, bus.alu_b};
        got_ops.push_back(alu_cur);
      end else begin
        check("alu_op_hold", 32'(bus.alu_op), 32'(alu_cur.op));
        check("alu_a_hold", bus.alu_a, alu_cur.a);
        check("alu_b_hold", bus.alu_b, alu_cur.b);
      end
      alu_cnt = alu_cnt + 1;
      bus.alu_ack    = (alu_cnt >= alu_lat);
      bus.alu_result = calc(alu_cur.op, alu_cur.a, alu_cur.b);
    end else begin
      alu_cnt = 0;
      bus.alu_ack = 1'b0;
      bus.alu_result = $urandom();
    end

    if (bus.out_stb) begin
      if (out_cnt == 0) begin
        got_out_n = got_out_n + 1;
        got_val   = bus.out_data;
        got_err   = bus.err;
      end else begin
        check("out_data_hold", bus.out_data, got_val);
        check("err_hold", 32'(bus.err), 32'(got_err));
      end
      out_cnt = out_cnt + 1;
      bus.out_ack = (out_cnt > out_dly);
    end else begin
      out_cnt = 0;
      bus.out_ack = 1'b0;
    end
  endtask

  task automatic send_token(input tok_t t, output int cyc);
    bus.in_stb   = 1'b1;
    bus.in_data  = t.d;
    bus.in_is_op = t.is_op;
    tok_active   = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc = cyc + 1;
    end while (!bus.in_ack && cyc < 100);
    if (!bus.in_ack) check("token_timeout", 32'(0), 32'(1));
    bus.in_stb   = 1'b0;
    bus.in_data  = $urandom();
    bus.in_is_op = 1'($urandom_range(0, 1));
    tok_active   = 1'b0;
  endtask

  task automatic add_num(input logic [W-1:0] v);
    tq.push_back({1'b0, v});
  endtask

  task automatic add_op(input logic [2:0] c);
    // upper bits of an operator token are junk on purpose
    tq.push_back({1'b1, 29'($urandom()), c});
  endtask

  function automatic logic [W-1:0] rnd_num();
    case ($urandom_range(0, 2))
      0:       return W'($urandom_range(0, 20));
      1:       return $urandom();
      default: return 32'hFFFF_FFF0 + W'($urandom_range(0, 15));
    endcase
  endfunction

  // Feed tq, then compare result, flags and ALU traffic with the model.
  // With gap set, an idle cycle precedes every token so latency is exact.
  task automatic run_expr(input string name, input bit gap);
    int cyc;
    model();
    got_ops.delete();
    got_out_n = 0;
    for (int i = 0; i < tq.size(); i++) begin
      if (gap) tick();
      send_token(tq[i], cyc);
      if (gap) begin
        if (!tq[i].is_op) check("lat_num", cyc, 2);
        else if (tq[i].d[2:0] inside {3'b001, 3'b010, 3'b011}) check("lat_op", cyc, 2 + alu_lat);
      end
    end
    check("out_count", got_out_n, 1);
    check("out_data", got_val, exp_res);
    check("err_at_out", 32'(got_err), 32'(exp_err));
    check("alu_op_count", got_ops.size(), exp_ops.size());
    for (int i = 0; i < got_ops.size() && i < exp_ops.size(); i++) begin
      check("alu_op", 32'(got_ops[i].op), 32'(exp_ops[i].op));
      check("alu_a", got_ops[i].a, exp_ops[i].a);
      check("alu_b", got_ops[i].b, exp_ops[i].b);
    end
    check("err_cleared", 32'(bus.err), 32'(0));
    check("out_stb_dropped", 32'(bus.out_stb), 32'(0));
    $display("expr %s: tokens=%0d result=%0h err=%b alu_ops=%0d", name, tq.size(), got_val,
             got_err, got_ops.size());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired before the end of the run");
    $fatal(1, "watchdog");
  end

  initial begin
    int depth;
    int k;
    int cyc;
    logic [2:0] c;

    bus.in_stb     = 1'b0;
    bus.in_data    = '0;
    bus.in_is_op   = 1'b0;
    bus.alu_ack    = 1'b0;
    bus.alu_result = '0;
    bus.out_ack    = 1'b0;

    // reset values
    repeat (3) @(negedge CLK);
    check("rst_in_ack", 32'(bus.in_ack), 32'(0));
    check("rst_alu_req", 32'(bus.alu_req), 32'(0));
    check("rst_alu_op", 32'(bus.alu_op), 32'(0));
    check("rst_alu_a", bus.alu_a, 32'(0));
    check("rst_alu_b", bus.alu_b, 32'(0));
    check("rst_out_stb", 32'(bus.out_stb), 32'(0));
    check("rst_out_data", bus.out_data, 32'(0));
    check("rst_err", 32'(bus.err), 32'(0));
    RST_N = 1'b1;

    // 3 4 + 2 * =  -> 14
    alu_lat = 1; out_dly = 0;
    tq.delete();
    add_num(3); add_num(4); add_op(3'b010); add_num(2); add_op(3'b001); add_op(3'b100);
    run_expr("mul_add", 1'b1);

    // 10 3 - =  -> 7
    tq.delete();
    add_num(10); add_num(3); add_op(3'b011); add_op(3'b100);
    run_expr("sub", 1'b1);

    // overflow on the 5th number, then recovery
    tq.delete();
    for (int i = 0; i < 5; i++) add_num(W'(i + 1));
    add_op(3'b100);
    run_expr("overflow", 1'b0);
    tq.delete();
    add_num(1); add_num(1); add_op(3'b010); add_op(3'b100);
    run_expr("after_overflow", 1'b0);

    // underflow on '+', then bad op code 110
    tq.delete();
    add_op(3'b010); add_op(3'b100);
    run_expr("underflow", 1'b0);
    tq.delete();
    add_op(3'b110); add_op(3'b100);
    run_expr("bad_op", 1'b0);
    tq.delete();
    add_num(8); add_op(3'b100);
    run_expr("after_bad_op", 1'b0);

    // slow ALU and slow output stage
    alu_lat = 7; out_dly = 5;
    tq.delete();
    add_num(9); add_num(5); add_op(3'b011); add_op(3'b100);
    run_expr("slow", 1'b1);

    // reset while waiting on the ALU with one entry left on the stack
    alu_lat = 1000; out_dly = 0;
    tq.delete();
    add_num(1);
    send_token(tq[0], cyc);
    add_num(7);
    send_token(tq[1], cyc);
    add_num(8);
    send_token(tq[2], cyc);
    bus.in_stb = 1'b1; bus.in_is_op = 1'b1; bus.in_data = 32'd1;
    tok_active = 1'b1;
    k = 0;
    do begin
      tick();
      k = k + 1;
    end while (!bus.alu_req && k < 20);
    check("pre_rst_alu_req", 32'(bus.alu_req), 32'(1));
    tick();
    tick();
    RST_N = 1'b0;
    #1;
    check("mid_rst_alu_req", 32'(bus.alu_req), 32'(0));
    check("mid_rst_in_ack", 32'(bus.in_ack), 32'(0));
    check("mid_rst_out_stb", 32'(bus.out_stb), 32'(0));
    check("mid_rst_alu_op", 32'(bus.alu_op), 32'(0));
    bus.in_stb = 1'b0;
    tok_active = 1'b0;
    bus.alu_ack = 1'b0;
    alu_cnt = 0;
    @(negedge CLK);
    RST_N = 1'b1;
    prev_ack = 1'b0;
    alu_lat = 2;
    tq.delete();
    add_num(5); add_num(6); add_op(3'b001); add_op(3'b100);
    run_expr("after_reset", 1'b0);

    // randomized expressions, mostly well-formed
    for (int n = 0; n < 40; n++) begin
      alu_lat = $urandom_range(1, 4);
      out_dly = $urandom_range(0, 3);
      tq.delete();
      if ($urandom_range(0, 9) < 7) begin
        depth = 0;
        k = $urandom_range(1, 6);
        for (int s = 0; s < k; s++) begin
          if (depth < 2 || (depth < D && $urandom_range(0, 1) == 1)) begin
            add_num(rnd_num());
            depth = depth + 1;
          end else begin
            add_op(3'($urandom_range(1, 3)));
            depth = depth - 1;
          end
        end
        while (depth > 1) begin
          add_op(3'($urandom_range(1, 3)));
          depth = depth - 1;
        end
        if (depth == 0) add_num(rnd_num());
      end else begin
        k = $urandom_range(1, 7);
        for (int s = 0; s < k; s++) begin
          if ($urandom_range(0, 9) < 6) begin
            add_num(rnd_num());
          end else begin
            c = 3'($urandom_range(0, 6));
            if (c >= 3'd4) c = c + 3'd1;
            add_op(c);
          end
        end
      end
      add_op(3'b100);
      run_expr($sformatf("rand%0d", n), 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
